seq_shift_add_multiplier: RTL and testbench
===========================================

Name: seq_shift_add_multiplier

Overview:
Iterative shift-and-add multiplier, parametrised in operand width and register-file size. Sits beside the datapath register file. On a start strobe carrying the multiply opcode, it selects two operands from the packed register bank, computes their product one multiplier bit per clock (unsigned or signed), and presents a 2*WIDTH result with a busy/done handshake. Result is held stable between operations.

Parameters:
WIDTH, 8, operand width in bits (>=2)
NREG, 4, number of registers in the packed input bank (power of 2, >=2)
OPCODE, 4'b1010, ctrl value that launches a multiply

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  launch request, sampled on clk rising edge
ctrl  input  4  operation code; multiply only when equal to OPCODE
regs  input  NREG*WIDTH  packed register bank; register k = regs[k*WIDTH +: WIDTH]
sel_a  input  $clog2(NREG)  multiplier operand register index
sel_b  input  $clog2(NREG)  multiplicand operand register index
signed_mode  input  1  1 = two's-complement operands/result, 0 = unsigned
dataout  output  2*WIDTH  product of the last completed operation
busy  output  1  high from the accept edge until the done cycle, inclusive
done  output  1  single-cycle pulse when dataout updates

Behaviour:
- Clock/reset: one clock (clk); reset asynchronous, active-low (rst_n). On rst_n=0: state=IDLE, dataout=0, busy=0, done=0, accumulator/counter/operand latches=0.
- States: IDLE, RUN, DONE.
- IDLE: accept when start=1 and ctrl==OPCODE. On the accept edge: latch A=regs[sel_a], B=regs[sel_b], mode=signed_mode; if mode: neg=A[W-1]^B[W-1], A and B replaced by magnitudes (zero-extended to WIDTH+1 bits so -2^(W-1) is exact); else neg=0. acc=0, count=0, busy=1 -> RUN. start with any other ctrl is ignored (no state change, done stays 0).
- RUN: each edge: if A[0]=1, acc += B_ext (B zero-extended to 2*WIDTH, shifted left by count); A shifts right 1; count++. After exactly WIDTH iterations (count==WIDTH-1 on the edge) -> DONE.
- DONE (one cycle): dataout = neg ? (~acc+1) truncated to 2*WIDTH : acc; done=1; busy=1 this cycle; next edge -> IDLE with busy=0, done=0.
- Latency: accept edge = E0; dataout and done valid after edge E0+WIDTH+1; next accept possible at edge E0+WIDTH+2. Throughput one result per WIDTH+2 cycles.
- Arithmetic: unsigned result range 0..(2^W-1)^2; signed range fits 2*WIDTH exactly (max (-2^(W-1))^2 = 2^(2W-2)). Zero operand in signed mode gives 0, never negative zero.
- Operand capture: regs/sel/signed_mode changes after E0 have no effect on the running operation. sel_a==sel_b is legal (squaring).
- start while busy (RUN or DONE): ignored, not queued.
- dataout changes only in DONE cycle; holds otherwise, including across ignored starts.
- Reset mid-operation: immediate abort, all outputs to reset values, no done pulse; first accept after rst_n release behaves normally.

Test Plan:
- WIDTH=8, unsigned, R0=0x0F, R1=0x11, sel_a=0, sel_b=1, start with ctrl=1010 -> busy for 10 cycles, done pulse after edge E0+9, dataout=0x00FF.
- Unsigned R2=0xFF, R3=0xFF -> dataout=0xFE01; then signed_mode=1, same regs (-1*-1) -> dataout=0x0001.
- Signed R0=0xFD (-3), R1=0x05 -> 0xFFF1; signed R0=R1=0x80, sel_a=sel_b=0 -> 0x4000; signed 0x80*0x01 -> 0xFF80.
- start with ctrl=0101 -> busy stays 0, no done, dataout unchanged; start re-asserted during RUN and regs changed mid-op -> ignored, result from E0 operands only.
- Assert rst_n=0 at iteration 4 -> dataout=0, busy=0, done=0 asynchronously; release, launch 0x03*0x04 -> dataout=0x000C after WIDTH+1 edges.
- Parametric: WIDTH=16, NREG=8, unsigned 0xFFFF*0xFFFF via sel 7,5 -> dataout=0xFFFE0001, done after edge E0+17.

Source files
------------

// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier
//   Iterative shift-and-add multiplier next to the datapath register file.
//   A start strobe carrying OPCODE latches two operands from the packed bank.
//   The block retires one multiplier bit per clock and presents a 2*WIDTH
//   product with a busy/done handshake. dataout holds between operations.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        launch request (accepted only in IDLE with ctrl == OPCODE)
//   ctrl         4-bit operation code
//   regs         packed bank, register k = regs[k*WIDTH +: WIDTH]
//   sel_a        multiplier register index
//   sel_b        multiplicand register index
//   signed_mode  1 = two's-complement operands/result, 0 = unsigned
//   dataout      product of the last completed operation
//   busy         high from the accept edge through the done cycle
//   done         one-cycle pulse when dataout updates
module seq_shift_add_multiplier #(
    parameter int          WIDTH  = 8,
    parameter int          NREG   = 4,
    parameter logic [3:0]  OPCODE = 4'b1010,
    localparam int         SW     = $clog2(NREG),
    localparam int         CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [3:0]            ctrl,
    input  logic [NREG*WIDTH-1:0] regs,
    input  logic [SW-1:0]         sel_a,
    input  logic [SW-1:0]         sel_b,
    input  logic                  signed_mode,
    output logic [2*WIDTH-1:0]    dataout,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state_q;
    logic [WIDTH-1:0]       a_q, b_q;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [CW-1:0]          cnt_q;
    logic                   neg_q;
    logic [2*WIDTH-1:0]     dataout_q;
    logic                   busy_q, done_q;

    logic [NREG-1:0][WIDTH-1:0] bank;
    logic [WIDTH-1:0]       a_sel, b_sel;
    logic [2*WIDTH-1:0]     b_shift;

    // Magnitude of a possibly-negative operand. An unsigned WIDTH-bit field
    // already holds 2^(WIDTH-1), so -2^(WIDTH-1) maps to itself exactly.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x,
                                             input logic             s);
        return (s && x[WIDTH-1]) ? (~x + 1'b1) : x;
    endfunction

    assign bank    = regs;
    assign a_sel   = bank[sel_a];
    assign b_sel   = bank[sel_b];
    assign b_shift = {{WIDTH{1'b0}}, b_q} << cnt_q;
    assign acc_d   = a_q[0] ? (acc_q + b_shift) : acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            dataout_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start && ctrl == OPCODE) begin
                        a_q     <= mag(a_sel, signed_mode);
                        b_q     <= mag(b_sel, signed_mode);
                        neg_q   <= signed_mode & (a_sel[WIDTH-1] ^ b_sel[WIDTH-1]);
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    a_q   <= a_q >> 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1))
                        state_q <= DONE;
                end
                DONE: begin
                    // Negating zero yields zero, so no negative-zero case.
                    dataout_q <= neg_q ? (~acc_q + 1'b1) : acc_q;
                    done_q    <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dataout = dataout_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
module tb_seq_shift_add_multiplier;

    logic        clk, rst_n, start, signed_mode;
    logic [3:0]  ctrl;
    logic [31:0] regs;
    logic [1:0]  sel_a, sel_b;
    logic [15:0] dataout;
    logic        busy, done;

    logic         start_w;
    logic [127:0] regs_w;
    logic [2:0]   sel_a_w, sel_b_w;
    logic [31:0]  dataout_w;
    logic         busy_w, done_w;

    int tests = 0;
    int fails = 0;

    seq_shift_add_multiplier #(.WIDTH(8), .NREG(4), .OPCODE(4'b1010)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ctrl(ctrl), .regs(regs),
        .sel_a(sel_a), .sel_b(sel_b), .signed_mode(signed_mode),
        .dataout(dataout), .busy(busy), .done(done)
    );

    seq_shift_add_multiplier #(.WIDTH(16), .NREG(8), .OPCODE(4'b1010)) u_wide (
        .clk(clk), .rst_n(rst_n), .start(start_w), .ctrl(ctrl), .regs(regs_w),
        .sel_a(sel_a_w), .sel_b(sel_b_w), .signed_mode(1'b0),
        .dataout(dataout_w), .busy(busy_w), .done(done_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_reg(input int k, input logic [7:0] v);
        regs[k*8 +: 8] = v;
    endtask

    // Drives a one-cycle start; returns #1 after the accept edge E0.
    task automatic launch(input logic [1:0] a, input logic [1:0] b, input logic sm);
        sel_a = a; sel_b = b; signed_mode = sm; ctrl = 4'b1010; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // n = edge count after E0 at which done is seen (-1 if never);
    // bc = number of samples (from E0 onwards) with busy high.
    task automatic wait_done(output int n, output int bc);
        n  = -1;
        bc = busy ? 1 : 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (busy) bc++;
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; start_w = 1'b0; ctrl = 4'b0000;
        regs = '0; regs_w = '0; sel_a = '0; sel_b = '0; signed_mode = 1'b0;
        sel_a_w = '0; sel_b_w = '0;
        @(posedge clk); #1;
        tests++;
        if (dataout !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: dataout=%h busy=%b done=%b, want 0000 0 0", dataout, busy, done);
        end
        tests++;
        if (dataout_w !== 32'h0 || busy_w !== 1'b0 || done_w !== 1'b0) begin
            fails++;
            $display("FAIL reset_state_wide: dataout=%h busy=%b done=%b, want 0 0 0", dataout_w, busy_w, done_w);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned_basic;
        int n, bc;
        set_reg(0, 8'h0F); set_reg(1, 8'h11);
        launch(2'd0, 2'd1, 1'b0);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_after_accept: got %b want 1", busy);
        end
        wait_done(n, bc);
        tests++;
        if (n !== 9) begin
            fails++;
            $display("FAIL done_latency: done after edge E0+%0d, want E0+9", n);
        end
        tests++;
        if (dataout !== 16'h00FF) begin
            fails++;
            $display("FAIL u_0F_x_11: got %h want 00FF", dataout);
        end
        tests++;
        if (bc !== 10) begin
            fails++;
            $display("FAIL busy_length: busy for %0d cycles, want 10", bc);
        end
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || dataout !== 16'h00FF) begin
            fails++;
            $display("FAIL after_done: busy=%b done=%b dataout=%h want 0 0 00FF", busy, done, dataout);
        end
    endtask

    task automatic test_ff_both_modes;
        int n, bc;
        set_reg(2, 8'hFF); set_reg(3, 8'hFF);
        launch(2'd2, 2'd3, 1'b0);
        wait_done(n, bc);
        tests++;
        if (n !== 9 || dataout !== 16'hFE01) begin
            fails++;
            $display("FAIL u_FF_x_FF: got %h at E0+%0d want FE01 at E0+9", dataout, n);
        end
        // Back-to-back: launch straight from the done cycle (edge E0+10).
        launch(2'd2, 2'd3, 1'b1);
        wait_done(n, bc);
        tests++;
        if (n !== 9 || dataout !== 16'h0001) begin
            fails++;
            $display("FAIL s_m1_x_m1: got %h at E0+%0d want 0001 at E0+9", dataout, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_signed;
        int n, bc;
        logic [7:0]  va [5] = '{8'hFD, 8'h80, 8'h80, 8'h00, 8'h7F};
        logic [7:0]  vb [5] = '{8'h05, 8'h80, 8'h01, 8'hFD, 8'h80};
        logic [15:0] ex [5] = '{16'hFFF1, 16'h4000, 16'hFF80, 16'h0000, 16'hC080};
        for (int i = 0; i < 5; i++) begin
            set_reg(0, va[i]); set_reg(1, vb[i]);
            // Equal operands exercise the squaring path with sel_a == sel_b.
            if (va[i] == vb[i]) launch(2'd0, 2'd0, 1'b1);
            else                launch(2'd0, 2'd1, 1'b1);
            wait_done(n, bc);
            tests++;
            if (n !== 9 || dataout !== ex[i]) begin
                fails++;
                $display("FAIL signed_%0d: %h*%h got %h at E0+%0d want %h at E0+9",
                         i, va[i], vb[i], dataout, n, ex[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_bad_ctrl;
        int seen_done;
        seen_done = 0;
        // Last result is 0x7F * 0x80 signed = -16256 = 0xC080.
        ctrl = 4'b0101; start = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL bad_ctrl_busy: got %b want 0", busy);
        end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen_done++;
        end
        start = 1'b0;
        tests++;
        if (seen_done !== 0 || dataout !== 16'hC080) begin
            fails++;
            $display("FAIL bad_ctrl_ignored: activity=%0d dataout=%h want 0 C080", seen_done, dataout);
        end
    endtask

    task automatic test_busy_ignore;
        int n, bc;
        set_reg(0, 8'h03); set_reg(1, 8'h07);
        launch(2'd0, 2'd1, 1'b0);
        // Re-strobe and scramble operands mid-run; must not affect result.
        start = 1'b1; ctrl = 4'b1010; signed_mode = 1'b1;
        set_reg(0, 8'hFF); set_reg(1, 8'hFF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n, bc);
        tests++;
        if (n !== 7 || dataout !== 16'h0015) begin
            fails++;
            $display("FAIL busy_ignore: got %h at +%0d want 0015 at +7", dataout, n);
        end
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL no_queued_start: busy=%b want 0", busy);
        end
        signed_mode = 1'b0;
    endtask

    task automatic test_reset_mid;
        int n, bc, act;
        act = 0;
        set_reg(0, 8'h0F); set_reg(1, 8'h11);
        launch(2'd0, 2'd1, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (dataout !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: dataout=%h busy=%b done=%b want 0000 0 0", dataout, busy, done);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done || busy) act++;
        end
        tests++;
        if (act !== 0) begin
            fails++;
            $display("FAIL reset_no_done: activity=%0d want 0", act);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        set_reg(0, 8'h03); set_reg(1, 8'h04);
        launch(2'd0, 2'd1, 1'b0);
        wait_done(n, bc);
        tests++;
        if (n !== 9 || dataout !== 16'h000C) begin
            fails++;
            $display("FAIL post_reset_op: got %h at E0+%0d want 000C at E0+9", dataout, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wide;
        int n;
        n = -1;
        regs_w = '0;
        regs_w[7*16 +: 16] = 16'hFFFF;
        regs_w[5*16 +: 16] = 16'hFFFF;
        sel_a_w = 3'd7; sel_b_w = 3'd5; ctrl = 4'b1010; start_w = 1'b1;
        @(posedge clk); #1;
        start_w = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done_w) begin
                n = i;
                break;
            end
        end
        tests++;
        if (n !== 17 || dataout_w !== 32'hFFFE0001) begin
            fails++;
            $display("FAIL wide_FFFF_sq: got %h at E0+%0d want FFFE0001 at E0+17", dataout_w, n);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_basic();
        test_ff_both_modes();
        test_signed();
        test_bad_ctrl();
        test_busy_ignore();
        test_reset_mid();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
